// File: rtl/emesh_wait_buffer.sv
// emesh_wait_buffer
//   Small circular FIFO that decouples an emesh transaction source from a
//   downstream arbiter. The head entry is presented first-word-fall-through
//   and is popped whenever the arbiter is not stalling its transaction type.
//
//   Upstream side:
//     in_access, in_write, in_datamode[1:0], in_ctrlmode[3:0],
//     in_dstaddr/in_srcaddr/in_data[31:0]   incoming transaction
//     in_wr_wait, in_rd_wait                 back-pressure (count >= DEPTH-1)
//   Downstream side:
//     out_access, out_write, out_datamode, out_ctrlmode,
//     out_dstaddr/out_srcaddr/out_data       head of queue
//     out_wr_wait, out_rd_wait               arbiter back-pressure
//   Status:
//     count      occupancy, 0..DEPTH
//     overflow   sticky, set when a transaction had to be dropped
//   eclk rising edge; reset asynchronous, active-high.
module emesh_wait_buffer #(
  parameter int DEPTH = 4
) (
  input  logic                     eclk,
  input  logic                     reset,
  input  logic                     in_access,
  input  logic                     in_write,
  input  logic [1:0]               in_datamode,
  input  logic [3:0]               in_ctrlmode,
  input  logic [31:0]              in_dstaddr,
  input  logic [31:0]              in_srcaddr,
  input  logic [31:0]              in_data,
  output logic                     in_wr_wait,
  output logic                     in_rd_wait,
  output logic                     out_access,
  output logic                     out_write,
  output logic [1:0]               out_datamode,
  output logic [3:0]               out_ctrlmode,
  output logic [31:0]              out_dstaddr,
  output logic [31:0]              out_srcaddr,
  output logic [31:0]              out_data,
  input  logic                     out_wr_wait,
  input  logic                     out_rd_wait,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     overflow
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL   = CW'(DEPTH);
  localparam logic [CW-1:0] ALMOST = CW'(DEPTH - 1);

  generate
    if ((DEPTH < 2) || ((DEPTH & (DEPTH - 1)) != 0)) begin : g_bad_depth
      $error("emesh_wait_buffer: DEPTH must be a power of 2 and >= 2");
    end
  endgenerate

  typedef struct packed {
    logic        write;
    logic [1:0]  datamode;
    logic [3:0]  ctrlmode;
    logic [31:0] dstaddr;
    logic [31:0] srcaddr;
    logic [31:0] data;
  } emesh_txn_t;

  emesh_txn_t        mem [DEPTH];
  emesh_txn_t        in_txn;
  emesh_txn_t        head;
  logic [AW-1:0]     wr_ptr;
  logic [AW-1:0]     rd_ptr;
  logic              stall;
  logic              push;
  logic              pop;

  assign in_txn = '{write:    in_write,
                    datamode: in_datamode,
                    ctrlmode: in_ctrlmode,
                    dstaddr:  in_dstaddr,
                    srcaddr:  in_srcaddr,
                    data:     in_data};

  // Fall-through head. While stalled the head slot cannot be overwritten:
  // wr_ptr only equals rd_ptr when empty or full, and a full, stalled
  // queue refuses pushes.
  assign head         = mem[rd_ptr];
  assign out_access   = (count != '0);
  assign out_write    = head.write;
  assign out_datamode = head.datamode;
  assign out_ctrlmode = head.ctrlmode;
  assign out_dstaddr  = head.dstaddr;
  assign out_srcaddr  = head.srcaddr;
  assign out_data     = head.data;

  // Stall follows the type of the head only, so a blocked read also holds
  // back every write queued behind it.
  assign stall = head.write ? out_wr_wait : out_rd_wait;
  assign pop   = out_access & ~stall;
  // When full, a same-cycle pop frees the slot under rd_ptr (== wr_ptr);
  // the old head is still read out this cycle before the write lands.
  assign push  = in_access & ((count != FULL) | pop);

  // Waits come from the registered count only; asserting one entry early
  // leaves room for a transaction already launched in the cycle the
  // source first sees the wait.
  assign in_wr_wait = (count >= ALMOST);
  assign in_rd_wait = (count >= ALMOST);

  // Storage carries no reset; contents are meaningless while out_access=0.
  always_ff @(posedge eclk) begin
    if (push) mem[wr_ptr] <= in_txn;
  end

  always_ff @(posedge eclk or posedge reset) begin
    if (reset) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      if (in_access & ~push) overflow <= 1'b1;
    end
  end

endmodule
